// File: rtl/fpnew_shared_apu_wrapper_if.sv
// Core-side APU channel bundle plus the shared FPnew request/response port.
// The wrapper takes the slave view; the cores and the FPU together are the master.
interface fpnew_shared_apu_wrapper_if #(
    parameter int NB_CH           = 4,
    parameter int ID_WIDTH        = 9,
    parameter int NB_ARGS         = 3,
    parameter int DATA_WIDTH      = 32,
    parameter int OPCODE_WIDTH    = 6,
    parameter int FLAGS_IN_WIDTH  = 15,
    parameter int FLAGS_OUT_WIDTH = 5
) ();
    localparam int TW = ID_WIDTH + $clog2(NB_CH);

    logic [NB_CH-1:0]                    apu_req_i;
    logic [NB_CH-1:0]                    apu_gnt_o;
    logic [NB_CH*ID_WIDTH-1:0]           apu_ID_i;
    logic [NB_CH*NB_ARGS*DATA_WIDTH-1:0] apu_operands_i;
    logic [NB_CH*OPCODE_WIDTH-1:0]       apu_op_i;
    logic [NB_CH*FLAGS_IN_WIDTH-1:0]     apu_flags_i;
    logic [NB_CH-1:0]                    apu_rready_i;
    logic [NB_CH-1:0]                    apu_rvalid_o;
    logic [DATA_WIDTH-1:0]               apu_rdata_o;
    logic [FLAGS_OUT_WIDTH-1:0]          apu_rflags_o;
    logic [ID_WIDTH-1:0]                 apu_rID_o;

    logic                                fpu_req_o;
    logic                                fpu_gnt_i;
    logic [NB_ARGS*DATA_WIDTH-1:0]       fpu_operands_o;
    logic [OPCODE_WIDTH-1:0]             fpu_op_o;
    logic [FLAGS_IN_WIDTH-1:0]           fpu_flags_o;
    logic [TW-1:0]                       fpu_tag_o;
    logic                                fpu_rvalid_i;
    logic [DATA_WIDTH-1:0]               fpu_rdata_i;
    logic [FLAGS_OUT_WIDTH-1:0]          fpu_rflags_i;
    logic [TW-1:0]                       fpu_rtag_i;

    modport master (
        output apu_req_i, apu_ID_i, apu_operands_i, apu_op_i, apu_flags_i,
        output apu_rready_i,
        output fpu_gnt_i, fpu_rvalid_i, fpu_rdata_i, fpu_rflags_i, fpu_rtag_i,
        input  apu_gnt_o, apu_rvalid_o, apu_rdata_o, apu_rflags_o, apu_rID_o,
        input  fpu_req_o, fpu_operands_o, fpu_op_o, fpu_flags_o, fpu_tag_o
    );

    modport slave (
        input  apu_req_i, apu_ID_i, apu_operands_i, apu_op_i, apu_flags_i,
        input  apu_rready_i,
        input  fpu_gnt_i, fpu_rvalid_i, fpu_rdata_i, fpu_rflags_i, fpu_rtag_i,
        output apu_gnt_o, apu_rvalid_o, apu_rdata_o, apu_rflags_o, apu_rID_o,
        output fpu_req_o, fpu_operands_o, fpu_op_o, fpu_flags_o, fpu_tag_o
    );
endinterface

// File: rtl/fpnew_shared_apu_wrapper.sv
// Round-robin sharing of one FPnew port among NB_CH APU channels, with a
// credit-protected response FIFO routing results back by tag.
module fpnew_shared_apu_wrapper #(
    parameter int NB_CH           = 4,
    parameter int ID_WIDTH        = 9,
    parameter int NB_ARGS         = 3,
    parameter int DATA_WIDTH      = 32,
    parameter int OPCODE_WIDTH    = 6,
    parameter int FLAGS_IN_WIDTH  = 15,
    parameter int FLAGS_OUT_WIDTH = 5,
    parameter int RESP_DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    fpnew_shared_apu_wrapper_if.slave bus,
    output logic                      busy_o,
    output logic                      ovf_err_o
);
    localparam int CH  = $clog2(NB_CH);
    localparam int OPW = NB_ARGS * DATA_WIDTH;
    localparam int AW  = $clog2(RESP_DEPTH);
    localparam int CW  = $clog2(RESP_DEPTH + 1);

    typedef struct packed {
        logic [CH-1:0]              chan;
        logic [ID_WIDTH-1:0]        id;
        logic [DATA_WIDTH-1:0]      data;
        logic [FLAGS_OUT_WIDTH-1:0] flags;
    } rsp_t;

    typedef enum logic {
        ARB_FREE,
        ARB_LOCKED
    } arb_state_e;

    arb_state_e    state_q, state_d;
    logic [CH-1:0] ptr_q;
    logic [CH-1:0] lock_q, lock_d;
    logic [CH-1:0] rr_win, winner;
    logic [CW-1:0] credits_q;
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          ovf_q;

    rsp_t mem [RESP_DEPTH];
    rsp_t head;

    logic fpu_req, hs;
    logic empty, full, pop, push;

    function automatic logic [CH-1:0] ch_add(
        input logic [CH-1:0] p,
        input int unsigned   n
    );
        logic [CH:0] s;
        s = {1'b0, p} + (CH+1)'(n);
        if (s >= (CH+1)'(NB_CH)) s = s - (CH+1)'(NB_CH);
        return s[CH-1:0];
    endfunction

    function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
        if (p[AW-1:0] == AW'(RESP_DEPTH - 1))
            return {~p[AW], {AW{1'b0}}};
        return p + (AW+1)'(1);
    endfunction

    // Walk backwards so the nearest requester at/after the pointer wins.
    always_comb begin
        rr_win = ptr_q;
        for (int i = NB_CH - 1; i >= 0; i--) begin
            if (bus.apu_req_i[ch_add(ptr_q, unsigned'(i))])
                rr_win = ch_add(ptr_q, unsigned'(i));
        end
    end

    assign winner  = (state_q == ARB_LOCKED) ? lock_q : rr_win;
    assign fpu_req = (|bus.apu_req_i) && (credits_q != '0);
    assign hs      = fpu_req && bus.fpu_gnt_i;

    assign bus.fpu_req_o = fpu_req;

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        unique case (state_q)
            ARB_FREE: begin
                if (fpu_req && !bus.fpu_gnt_i) begin
                    state_d = ARB_LOCKED;
                    lock_d  = winner;
                end
            end
            ARB_LOCKED: begin
                if (hs) state_d = ARB_FREE;
            end
        endcase
    end

    always_comb begin
        bus.fpu_operands_o = '0;
        bus.fpu_op_o       = '0;
        bus.fpu_flags_o    = '0;
        bus.fpu_tag_o      = '0;
        bus.apu_gnt_o      = '0;
        for (int k = 0; k < NB_CH; k++) begin
            if (fpu_req && winner == CH'(k)) begin
                bus.fpu_operands_o = bus.apu_operands_i[k*OPW +: OPW];
                bus.fpu_op_o       = bus.apu_op_i[k*OPCODE_WIDTH +: OPCODE_WIDTH];
                bus.fpu_flags_o    = bus.apu_flags_i[k*FLAGS_IN_WIDTH +: FLAGS_IN_WIDTH];
                bus.fpu_tag_o      = {CH'(k), bus.apu_ID_i[k*ID_WIDTH +: ID_WIDTH]};
                bus.apu_gnt_o[k]   = bus.fpu_gnt_i;
            end
        end
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0])
                && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign head  = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        bus.apu_rvalid_o = '0;
        pop              = 1'b0;
        for (int k = 0; k < NB_CH; k++) begin
            if (!empty && head.chan == CH'(k)) begin
                bus.apu_rvalid_o[k] = 1'b1;
                pop                 = bus.apu_rready_i[k];
            end
        end
    end

    // A full FIFO still accepts a response when its head leaves this cycle.
    assign push = bus.fpu_rvalid_i && (!full || pop);

    assign bus.apu_rdata_o  = empty ? '0 : head.data;
    assign bus.apu_rflags_o = empty ? '0 : head.flags;
    assign bus.apu_rID_o    = empty ? '0 : head.id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ARB_FREE;
            lock_q    <= '0;
            ptr_q     <= '0;
            credits_q <= CW'(RESP_DEPTH);
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            if (hs) ptr_q <= ch_add(winner, 1);
            unique case ({hs, pop})
                2'b10:   credits_q <= credits_q - CW'(1);
                2'b01:   credits_q <= credits_q + CW'(1);
                default: credits_q <= credits_q;
            endcase
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (bus.fpu_rvalid_i && !push) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_q[AW-1:0]] <= {bus.fpu_rtag_i, bus.fpu_rdata_i, bus.fpu_rflags_i};
    end

    assign busy_o    = (credits_q != CW'(RESP_DEPTH));
    assign ovf_err_o = ovf_q;
endmodule

// File: tb/tb_fpnew_shared_apu_wrapper.sv
// Directed scenarios plus randomized traffic against a queue-based model
// of the shared APU wrapper.
module tb_fpnew_shared_apu_wrapper;
    localparam int NCH   = 4;
    localparam int IDW   = 9;
    localparam int OPW   = 96;
    localparam int DEPTH = 4;

    typedef struct {
        int         ch;
        logic [8:0]  id;
        logic [31:0] d;
        logic [4:0]  f;
        int          due;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, ovf;
    int   cmps = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    fpnew_shared_apu_wrapper_if bus ();

    fpnew_shared_apu_wrapper dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .busy_o    (busy),
        .ovf_err_o (ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        bus.apu_req_i      = '0;
        bus.apu_ID_i       = '0;
        bus.apu_operands_i = '0;
        bus.apu_op_i       = '0;
        bus.apu_flags_i    = '0;
        bus.apu_rready_i   = '0;
        bus.fpu_gnt_i      = 1'b0;
        bus.fpu_rvalid_i   = 1'b0;
        bus.fpu_rdata_i    = '0;
        bus.fpu_rflags_i   = '0;
        bus.fpu_rtag_i     = '0;
    endtask

    task automatic set_ch(input int c, input logic [8:0] id, input logic [95:0] ops,
                          input logic [5:0] op, input logic [14:0] fl);
        bus.apu_ID_i[c*IDW +: IDW]       = id;
        bus.apu_operands_i[c*OPW +: OPW] = ops;
        bus.apu_op_i[c*6 +: 6]           = op;
        bus.apu_flags_i[c*15 +: 15]      = fl;
    endtask

    task automatic fpu_ret(input int c, input logic [8:0] id, input logic [31:0] d);
        bus.fpu_rvalid_i = 1'b1;
        bus.fpu_rtag_i   = {2'(c), id};
        bus.fpu_rdata_i  = d;
        bus.fpu_rflags_i = 5'(c + 1);
    endtask

    task automatic do_reset();
        clr_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        clr_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cmps++; if (bus.apu_gnt_o !== 4'b0) begin errs++; $display("FAIL rst_gnt: got %b exp 0000", bus.apu_gnt_o); end
        cmps++; if (bus.apu_rvalid_o !== 4'b0) begin errs++; $display("FAIL rst_rvalid: got %b exp 0000", bus.apu_rvalid_o); end
        cmps++; if (bus.fpu_req_o !== 1'b0) begin errs++; $display("FAIL rst_fpureq: got %b exp 0", bus.fpu_req_o); end
        cmps++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b exp 0", busy); end
        cmps++; if (ovf !== 1'b0) begin errs++; $display("FAIL rst_ovf: got %b exp 0", ovf); end
        cmps++; if (bus.apu_rdata_o !== 32'h0) begin errs++; $display("FAIL rst_rdata: got %h exp 0", bus.apu_rdata_o); end
        cmps++; if (bus.fpu_tag_o !== 11'h0) begin errs++; $display("FAIL rst_tag: got %h exp 0", bus.fpu_tag_o); end
        rst = 1'b0;
        tick();
        cmps++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy_rel: got %b exp 0", busy); end
    endtask

    task automatic test_single_op();
        do_reset();
        set_ch(2, 9'h15, 96'h1234, 6'h3, 15'h7);
        bus.apu_req_i = 4'b0100;
        bus.fpu_gnt_i = 1'b1;
        #1;
        cmps++; if (bus.apu_gnt_o !== 4'b0100) begin errs++; $display("FAIL single_gnt: got %b exp 0100", bus.apu_gnt_o); end
        cmps++; if (bus.fpu_tag_o !== {2'd2, 9'h15}) begin errs++; $display("FAIL single_tag: got %h exp %h", bus.fpu_tag_o, {2'd2, 9'h15}); end
        cmps++; if (bus.fpu_operands_o !== 96'h1234) begin errs++; $display("FAIL single_ops: got %h exp 1234", bus.fpu_operands_o); end
        tick();
        bus.apu_req_i = '0;
        repeat (2) tick();
        fpu_ret(2, 9'h15, 32'h3F80_0000);
        #1;
        cmps++; if (bus.apu_rvalid_o !== 4'b0) begin errs++; $display("FAIL single_nofall: got %b exp 0000", bus.apu_rvalid_o); end
        cmps++; if (busy !== 1'b1) begin errs++; $display("FAIL single_busy: got %b exp 1", busy); end
        tick();
        bus.fpu_rvalid_i = 1'b0;
        bus.apu_rready_i = 4'b0100;
        #1;
        cmps++; if (bus.apu_rvalid_o !== 4'b0100) begin errs++; $display("FAIL single_rvalid: got %b exp 0100", bus.apu_rvalid_o); end
        cmps++; if (bus.apu_rID_o !== 9'h15) begin errs++; $display("FAIL single_rid: got %h exp 15", bus.apu_rID_o); end
        cmps++; if (bus.apu_rdata_o !== 32'h3F80_0000) begin errs++; $display("FAIL single_rdata: got %h exp 3f800000", bus.apu_rdata_o); end
        tick();
        cmps++; if (bus.apu_rvalid_o !== 4'b0) begin errs++; $display("FAIL single_popped: got %b exp 0000", bus.apu_rvalid_o); end
        cmps++; if (busy !== 1'b0) begin errs++; $display("FAIL single_idle: got %b exp 0", busy); end
    endtask

    task automatic test_round_robin();
        int pch = -1;
        do_reset();
        for (int c = 0; c < NCH; c++) set_ch(c, 9'(256 + c), 96'(c), 6'(c), 15'(c));
        bus.apu_req_i    = '1;
        bus.fpu_gnt_i    = 1'b1;
        bus.apu_rready_i = '1;
        for (int i = 0; i < 12; i++) begin
            bus.fpu_rvalid_i = 1'b0;
            if (pch >= 0) fpu_ret(pch, 9'(256 + pch), 32'(i));
            #1;
            cmps++; if (bus.apu_gnt_o !== 4'(1 << (i % NCH))) begin errs++; $display("FAIL rr_gnt%0d: got %b exp %b", i, bus.apu_gnt_o, 4'(1 << (i % NCH))); end
            pch = i % NCH;
            tick();
        end
    endtask

    task automatic test_credit_stall();
        int ng = 0;
        do_reset();
        for (int c = 0; c < NCH; c++) set_ch(c, 9'(32 + c), 96'(c), 6'(c), 15'(c));
        bus.apu_req_i = '1;
        bus.fpu_gnt_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.fpu_rvalid_i = 1'b0;
            if (i >= 1 && i <= 4) fpu_ret(i - 1, 9'(32 + i - 1), 32'(i));
            #1;
            ng += $countones(bus.apu_gnt_o);
            tick();
        end
        bus.fpu_rvalid_i = 1'b0;
        #1;
        cmps++; if (ng !== 4) begin errs++; $display("FAIL credit_grants: got %0d exp 4", ng); end
        cmps++; if (bus.fpu_req_o !== 1'b0) begin errs++; $display("FAIL credit_req: got %b exp 0", bus.fpu_req_o); end
        bus.apu_rready_i = 4'b0001;
        #1;
        cmps++; if (bus.apu_rvalid_o !== 4'b0001) begin errs++; $display("FAIL credit_head: got %b exp 0001", bus.apu_rvalid_o); end
        tick();
        bus.apu_rready_i = '0;
        ng = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            ng += $countones(bus.apu_gnt_o);
            tick();
        end
        cmps++; if (ng !== 1) begin errs++; $display("FAIL credit_regrant: got %0d exp 1", ng); end
    endtask

    task automatic test_hol();
        do_reset();
        set_ch(1, 9'h0A1, 96'h11, 6'h1, 15'h1);
        set_ch(3, 9'h0B3, 96'h33, 6'h3, 15'h3);
        bus.fpu_gnt_i = 1'b1;
        bus.apu_req_i = 4'b0010;
        #1;
        cmps++; if (bus.apu_gnt_o !== 4'b0010) begin errs++; $display("FAIL hol_gnt1: got %b exp 0010", bus.apu_gnt_o); end
        tick();
        bus.apu_req_i = 4'b1000;
        fpu_ret(1, 9'h0A1, 32'hAAAA_0001);
        #1;
        cmps++; if (bus.apu_gnt_o !== 4'b1000) begin errs++; $display("FAIL hol_gnt3: got %b exp 1000", bus.apu_gnt_o); end
        tick();
        bus.apu_req_i = '0;
        fpu_ret(3, 9'h0B3, 32'hBBBB_0003);
        tick();
        bus.fpu_rvalid_i = 1'b0;
        bus.apu_rready_i = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            #1;
            cmps++; if (bus.apu_rvalid_o !== 4'b0010) begin errs++; $display("FAIL hol_hold%0d: got %b exp 0010", i, bus.apu_rvalid_o); end
            cmps++; if (bus.apu_rID_o !== 9'h0A1) begin errs++; $display("FAIL hol_rid%0d: got %h exp 0a1", i, bus.apu_rID_o); end
            tick();
        end
        bus.apu_rready_i = 4'b1010;
        tick();
        cmps++; if (bus.apu_rvalid_o !== 4'b1000) begin errs++; $display("FAIL hol_next: got %b exp 1000", bus.apu_rvalid_o); end
        cmps++; if (bus.apu_rdata_o !== 32'hBBBB_0003) begin errs++; $display("FAIL hol_data: got %h exp bbbb0003", bus.apu_rdata_o); end
        tick();
        cmps++; if (bus.apu_rvalid_o !== 4'b0) begin errs++; $display("FAIL hol_empty: got %b exp 0000", bus.apu_rvalid_o); end
    endtask

    task automatic test_fpu_stall_lock();
        do_reset();
        set_ch(0, 9'h044, 96'h40, 6'h0, 15'h0);
        bus.apu_req_i = 4'b0001;
        bus.fpu_gnt_i = 1'b1;
        tick();
        set_ch(0, 9'h055, 96'h50, 6'h5, 15'h5);
        set_ch(1, 9'h066, 96'h60, 6'h6, 15'h6);
        bus.fpu_gnt_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.apu_req_i = (i == 0) ? 4'b0001 : 4'b0011;
            #1;
            cmps++; if (bus.fpu_tag_o !== {2'd0, 9'h055}) begin errs++; $display("FAIL lock_tag%0d: got %h exp %h", i, bus.fpu_tag_o, {2'd0, 9'h055}); end
            cmps++; if (bus.apu_gnt_o !== 4'b0) begin errs++; $display("FAIL lock_nogrant%0d: got %b exp 0000", i, bus.apu_gnt_o); end
            tick();
        end
        bus.fpu_gnt_i = 1'b1;
        #1;
        cmps++; if (bus.apu_gnt_o !== 4'b0001) begin errs++; $display("FAIL lock_first: got %b exp 0001", bus.apu_gnt_o); end
        tick();
        bus.apu_req_i = 4'b0010;
        #1;
        cmps++; if (bus.apu_gnt_o !== 4'b0010) begin errs++; $display("FAIL lock_second: got %b exp 0010", bus.apu_gnt_o); end
        cmps++; if (bus.fpu_tag_o !== {2'd1, 9'h066}) begin errs++; $display("FAIL lock_tag1: got %h exp %h", bus.fpu_tag_o, {2'd1, 9'h066}); end
        tick();
    endtask

    task automatic test_overflow_reset();
        do_reset();
        for (int c = 0; c < NCH; c++) set_ch(c, 9'(16 + c), 96'(c), 6'(c), 15'(c));
        bus.apu_req_i = '1;
        bus.fpu_gnt_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.fpu_rvalid_i = 1'b0;
            if (i >= 1) fpu_ret(i - 1, 9'(16 + i - 1), 32'(100 + i));
            if (i == 4) bus.apu_req_i = '0;
            #1;
            if (i < 4) begin
                cmps++; if (bus.apu_gnt_o !== 4'(1 << i)) begin errs++; $display("FAIL ovf_fill%0d: got %b exp %b", i, bus.apu_gnt_o, 4'(1 << i)); end
            end
            tick();
        end
        fpu_ret(0, 9'h1FF, 32'hDEAD_BEEF);
        #1;
        cmps++; if (ovf !== 1'b0) begin errs++; $display("FAIL ovf_pre: got %b exp 0", ovf); end
        tick();
        bus.fpu_rvalid_i = 1'b0;
        #1;
        cmps++; if (ovf !== 1'b1) begin errs++; $display("FAIL ovf_set: got %b exp 1", ovf); end
        bus.apu_rready_i = '1;
        for (int k = 0; k < 3; k++) begin
            #1;
            cmps++; if (bus.apu_rID_o !== 9'(16 + k)) begin errs++; $display("FAIL ovf_order%0d: got %h exp %h", k, bus.apu_rID_o, 9'(16 + k)); end
            tick();
        end
        bus.apu_rready_i = '0;
        bus.apu_req_i    = 4'b0011;
        #1;
        cmps++; if (bus.apu_rID_o !== 9'h013) begin errs++; $display("FAIL ovf_dropped: got %h exp 013", bus.apu_rID_o); end
        cmps++; if (bus.apu_gnt_o !== 4'b0001) begin errs++; $display("FAIL mid_g0: got %b exp 0001", bus.apu_gnt_o); end
        tick();
        #1;
        cmps++; if (bus.apu_gnt_o !== 4'b0010) begin errs++; $display("FAIL mid_g1: got %b exp 0010", bus.apu_gnt_o); end
        tick();
        bus.apu_req_i = '0;
        #1;
        cmps++; if (busy !== 1'b1) begin errs++; $display("FAIL mid_busy: got %b exp 1", busy); end
        rst = 1'b1;
        #1;
        cmps++; if (bus.apu_rvalid_o !== 4'b0) begin errs++; $display("FAIL mid_rvalid: got %b exp 0000", bus.apu_rvalid_o); end
        cmps++; if (bus.apu_rID_o !== 9'h0) begin errs++; $display("FAIL mid_rid: got %h exp 0", bus.apu_rID_o); end
        cmps++; if (busy !== 1'b0) begin errs++; $display("FAIL mid_busy_clr: got %b exp 0", busy); end
        cmps++; if (ovf !== 1'b0) begin errs++; $display("FAIL mid_ovf_clr: got %b exp 0", ovf); end
        tick();
        rst = 1'b0;
        repeat (3) tick();
        cmps++; if (bus.apu_rvalid_o !== 4'b0) begin errs++; $display("FAIL mid_stale: got %b exp 0000", bus.apu_rvalid_o); end
    endtask

    task automatic test_random();
        ent_t        infl[$];
        ent_t        fq[$];
        ent_t        e;
        logic [3:0]  pend = '0;
        logic [8:0]  pid[NCH];
        logic [95:0] pops[NCH];
        logic [5:0]  pop_c[NCH];
        logic [14:0] pfl[NCH];
        int          ptr = 0;
        int          lk = 0;
        int          win, cr;
        bit          locked = 0;
        bit          ereq, ret, stop;
        logic [3:0]  egnt, erv;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            stop = (cyc >= 2000);
            if (stop && pend == '0 && infl.size() == 0 && fq.size() == 0) break;
            for (int c = 0; c < NCH; c++) begin
                if (!stop && !pend[c] && $urandom_range(99) < 35) begin
                    pend[c]  = 1'b1;
                    pid[c]   = 9'($urandom);
                    pops[c]  = {$urandom, $urandom, $urandom};
                    pop_c[c] = 6'($urandom);
                    pfl[c]   = 15'($urandom);
                    set_ch(c, pid[c], pops[c], pop_c[c], pfl[c]);
                end
            end
            bus.apu_req_i    = pend;
            bus.fpu_gnt_i    = ($urandom_range(99) < 70);
            bus.apu_rready_i = 4'($urandom);
            ret = (infl.size() > 0) && (infl[0].due <= cyc);
            bus.fpu_rvalid_i = ret;
            if (ret) begin
                bus.fpu_rtag_i   = {2'(infl[0].ch), infl[0].id};
                bus.fpu_rdata_i  = infl[0].d;
                bus.fpu_rflags_i = infl[0].f;
            end
            #1;
            cr   = DEPTH - infl.size() - fq.size();
            ereq = (pend != '0) && (cr > 0);
            win  = ptr;
            if (locked) win = lk;
            else begin
                for (int i = NCH - 1; i >= 0; i--)
                    if (pend[(ptr + i) % NCH]) win = (ptr + i) % NCH;
            end
            egnt = (ereq && bus.fpu_gnt_i) ? 4'(1 << win) : 4'b0;
            erv  = (fq.size() > 0) ? 4'(1 << fq[0].ch) : 4'b0;
            cmps++; if (bus.fpu_req_o !== ereq) begin errs++; $display("FAIL rnd_req c%0d: got %b exp %b", cyc, bus.fpu_req_o, ereq); end
            cmps++; if (bus.apu_gnt_o !== egnt) begin errs++; $display("FAIL rnd_gnt c%0d: got %b exp %b", cyc, bus.apu_gnt_o, egnt); end
            if (ereq) begin
                cmps++; if (bus.fpu_tag_o !== {2'(win), pid[win]}) begin errs++; $display("FAIL rnd_tag c%0d: got %h exp %h", cyc, bus.fpu_tag_o, {2'(win), pid[win]}); end
                cmps++; if ({bus.fpu_operands_o, bus.fpu_op_o, bus.fpu_flags_o} !== {pops[win], pop_c[win], pfl[win]}) begin errs++; $display("FAIL rnd_fields c%0d: got %h exp %h", cyc, bus.fpu_operands_o, pops[win]); end
            end
            cmps++; if (bus.apu_rvalid_o !== erv) begin errs++; $display("FAIL rnd_rvalid c%0d: got %b exp %b", cyc, bus.apu_rvalid_o, erv); end
            if (fq.size() > 0) begin
                cmps++; if ({bus.apu_rID_o, bus.apu_rdata_o, bus.apu_rflags_o} !== {fq[0].id, fq[0].d, fq[0].f}) begin errs++; $display("FAIL rnd_rdata c%0d: got %h/%h exp %h/%h", cyc, bus.apu_rID_o, bus.apu_rdata_o, fq[0].id, fq[0].d); end
            end
            cmps++; if (busy !== (cr != DEPTH)) begin errs++; $display("FAIL rnd_busy c%0d: got %b exp %b", cyc, busy, cr != DEPTH); end
            if (ereq && !bus.fpu_gnt_i) begin
                locked = 1;
                lk     = win;
            end
            if (fq.size() > 0 && bus.apu_rready_i[fq[0].ch]) void'(fq.pop_front());
            if (ret) fq.push_back(infl.pop_front());
            if (ereq && bus.fpu_gnt_i) begin
                locked    = 0;
                ptr       = (win + 1) % NCH;
                pend[win] = 1'b0;
                e.ch  = win;
                e.id  = pid[win];
                e.d   = $urandom;
                e.f   = 5'($urandom);
                e.due = cyc + int'($urandom_range(1, 4));
                infl.push_back(e);
            end
            tick();
        end
        cmps++; if (infl.size() + fq.size() != 0 || pend != '0) begin errs++; $display("FAIL rnd_drain: got %0d outstanding exp 0", infl.size() + fq.size()); end
        bus.fpu_rvalid_i = 1'b0;
        #1;
        cmps++; if (busy !== 1'b0) begin errs++; $display("FAIL rnd_idle: got %b exp 0", busy); end
    endtask

    initial begin
        clr_inputs();
        test_reset();
        test_single_op();
        test_round_robin();
        test_credit_stall();
        test_hol();
        test_fpu_stall_lock();
        test_overflow_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end
endmodule
